// File: rtl/traffic_ctrl_pkg.sv
// Shared definitions for the traffic-generator sequencer: command encodings, descriptor
// and flit-buffer field layout, FSM state type and descriptor helpers.
package traffic_ctrl_pkg;

   localparam int VC_BIT_SIZE     = 2;
   localparam int OP_SIZE         = 3;
   localparam int DATA_BIT_SIZE   = 32;
   localparam int BUFFER_BIT_SIZE = 40;
   localparam int FLIT_CNT_W      = 20;

   // Descriptor (Fill-format) word layout
   localparam int DATA_NUM_FLIT_LSB = 0;
   localparam int DATA_NUM_FLIT_W   = 8;
   localparam int DATA_VC_LSB       = 8;
   localparam int DATA_DST_LSB      = 10;
   localparam int DATA_DST_W        = 8;

   // Init payload: total packet count minus one
   localparam int INIT_TOTAL_LSB = 0;
   localparam int INIT_TOTAL_W   = 11;

   // Generator flit register layout
   localparam int BUFFER_VC_LSB = 32;
   localparam int FLIT_HEAD_BIT = 34;
   localparam int FLIT_TAIL_BIT = 35;

   typedef enum logic [OP_SIZE-1:0] {
      OP_NOP      = 3'd0,
      OP_INIT     = 3'd1,
      OP_FILL     = 3'd2,
      OP_PREDEQUE = 3'd3,
      OP_DEQUEUE  = 3'd4
   } op_t;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      FILL  = 3'd2,
      PRIME = 3'd3,
      WAIT1 = 3'd4,
      RUN   = 3'd5
   } state_t;

   // A zero-length descriptor still produces one flit.
   function automatic logic [FLIT_CNT_W-1:0] flit_count(input logic [DATA_BIT_SIZE-1:0] desc);
      logic [DATA_NUM_FLIT_W-1:0] n;
      n = desc[DATA_NUM_FLIT_LSB +: DATA_NUM_FLIT_W];
      return (n == '0) ? FLIT_CNT_W'(1) : FLIT_CNT_W'(n);
   endfunction

   function automatic logic [DATA_BIT_SIZE-1:0] build_desc(input int dst, input int vc, input int nflit);
      logic [DATA_BIT_SIZE-1:0] d;
      d = '0;
      d[DATA_DST_LSB +: DATA_DST_W]           = DATA_DST_W'(dst);
      d[DATA_VC_LSB +: VC_BIT_SIZE]           = VC_BIT_SIZE'(vc);
      d[DATA_NUM_FLIT_LSB +: DATA_NUM_FLIT_W] = DATA_NUM_FLIT_W'(nflit);
      return d;
   endfunction

endpackage

// File: rtl/traffic_ctrl_credit.sv
// Per-VC downstream credit counter: resets full, counts returns up (saturating) and sends down.
module credit_counter #(
   parameter int CREDIT_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic nonzero
);

   localparam int CW = $clog2(CREDIT_MAX + 1);
   localparam logic [CW-1:0] MAX_VAL = CW'(CREDIT_MAX);

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   // A return and a send together cancel; a return while full is dropped.
   always_comb begin
      count_next = count_reg;
      case ({inc, dec})
         2'b10:   if (count_reg != MAX_VAL) count_next = count_reg + 1'b1;
         2'b01:   if (count_reg != '0)      count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_reg <= MAX_VAL;
      else        count_reg <= count_next;
   end

   assign nonzero = (count_reg != '0);

endmodule

// File: rtl/traffic_ctrl.sv
// Sequencer for one traffic generator: Init, Fill xN, PreDeque, then credit-gated Dequeue.
// Optional TRAFFIC_CTRL_RATE_EN adds a rate_gap input spacing successive Dequeues.
module traffic_ctrl
   import traffic_ctrl_pkg::*;
#(
   parameter int NUM_VC     = 4,
   parameter int CREDIT_MAX = 4,
   parameter int MAX_PKTS   = 1024
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [10:0]                num_pkts,
`ifdef TRAFFIC_CTRL_RATE_EN
   input  logic [7:0]                 rate_gap,
`endif
   input  logic                       cfg_valid,
   output logic                       cfg_ready,
   input  logic [DATA_BIT_SIZE-1:0]   cfg_data,
   output logic [OP_SIZE-1:0]         tr_op,
   output logic [DATA_BIT_SIZE-1:0]   tr_data,
   input  logic [BUFFER_BIT_SIZE-1:0] tr_buffer,
   input  logic [NUM_VC-1:0]          credit_ret,
   output logic                       flit_valid,
   output logic                       busy,
   output logic                       finished,
   output logic [FLIT_CNT_W-1:0]      sent_flits
);

   localparam int PKT_CNT_W = $clog2(MAX_PKTS) + 1;

   state_t                 state_reg, state_next;
   logic [PKT_CNT_W-1:0]   num_pkts_reg, num_pkts_next;
   logic [PKT_CNT_W-1:0]   pkt_cnt_reg, pkt_cnt_next;
   logic [FLIT_CNT_W-1:0]  flit_total_reg, flit_total_next;
   logic [FLIT_CNT_W-1:0]  sent_flits_reg, sent_flits_next;
   op_t                    op;
   logic                   send;
   logic                   gap_ok;
   logic [NUM_VC-1:0]      credit_nz;
   logic [VC_BIT_SIZE-1:0] vc;

   assign vc = tr_buffer[BUFFER_VC_LSB +: VC_BIT_SIZE];

   // Flit payload and head/tail markers belong to the generator; only the VC steers us.
   logic unused_buffer_bits;
   assign unused_buffer_bits = ^{tr_buffer[BUFFER_BIT_SIZE-1:FLIT_TAIL_BIT+1], tr_buffer[FLIT_TAIL_BIT],
                                 tr_buffer[FLIT_HEAD_BIT], tr_buffer[BUFFER_VC_LSB-1:0]};

   always_comb begin
      state_next      = state_reg;
      num_pkts_next   = num_pkts_reg;
      pkt_cnt_next    = pkt_cnt_reg;
      flit_total_next = flit_total_reg;
      sent_flits_next = sent_flits_reg;
      op              = OP_NOP;
      tr_data         = '0;
      cfg_ready       = 1'b0;
      flit_valid      = 1'b0;
      finished        = 1'b0;
      send            = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next      = INIT;
               num_pkts_next   = PKT_CNT_W'(num_pkts);
               pkt_cnt_next    = '0;
               flit_total_next = '0;
               sent_flits_next = '0;
            end
         end
         INIT: begin
            op = OP_INIT;
            tr_data[INIT_TOTAL_LSB +: INIT_TOTAL_W] = INIT_TOTAL_W'(num_pkts_reg - 1'b1);
            state_next = FILL;
         end
         FILL: begin
            // Only reachable with pkt_cnt == num_pkts when the run was started empty.
            if (pkt_cnt_reg == num_pkts_reg) begin
               finished   = 1'b1;
               state_next = IDLE;
            end else begin
               cfg_ready = 1'b1;
               if (cfg_valid) begin
                  op              = OP_FILL;
                  tr_data         = cfg_data;
                  pkt_cnt_next    = pkt_cnt_reg + 1'b1;
                  flit_total_next = flit_total_reg + flit_count(cfg_data);
                  if (pkt_cnt_reg + 1'b1 == num_pkts_reg) state_next = PRIME;
               end
            end
         end
         PRIME: begin
            op         = OP_PREDEQUE;
            state_next = WAIT1;
         end
         WAIT1: begin
            state_next = RUN;
         end
         RUN: begin
            if (gap_ok && credit_nz[vc]) begin
               send            = 1'b1;
               op              = OP_DEQUEUE;
               flit_valid      = 1'b1;
               sent_flits_next = sent_flits_reg + 1'b1;
               if (sent_flits_reg + 1'b1 == flit_total_reg) begin
                  finished   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         num_pkts_reg   <= '0;
         pkt_cnt_reg    <= '0;
         flit_total_reg <= '0;
         sent_flits_reg <= '0;
      end else begin
         state_reg      <= state_next;
         num_pkts_reg   <= num_pkts_next;
         pkt_cnt_reg    <= pkt_cnt_next;
         flit_total_reg <= flit_total_next;
         sent_flits_reg <= sent_flits_next;
      end
   end

`ifdef TRAFFIC_CTRL_RATE_EN
   logic [7:0] rate_gap_reg, rate_gap_next;
   logic [7:0] gap_cnt_reg, gap_cnt_next;

   // The gap counts down every RUN cycle, so credit stalls overlap with it.
   always_comb begin
      rate_gap_next = rate_gap_reg;
      gap_cnt_next  = gap_cnt_reg;
      if (state_reg == IDLE && start) begin
         rate_gap_next = rate_gap;
         gap_cnt_next  = '0;
      end else if (state_reg == RUN) begin
         if (send)                    gap_cnt_next = rate_gap_reg;
         else if (gap_cnt_reg != '0)  gap_cnt_next = gap_cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rate_gap_reg <= '0;
         gap_cnt_reg  <= '0;
      end else begin
         rate_gap_reg <= rate_gap_next;
         gap_cnt_reg  <= gap_cnt_next;
      end
   end

   assign gap_ok = (gap_cnt_reg == '0);
`else
   assign gap_ok = 1'b1;
`endif

   generate
      for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_credit
         credit_counter #(
            .CREDIT_MAX (CREDIT_MAX)
         ) u_credit (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (credit_ret[gi]),
            .dec     (send && (vc == VC_BIT_SIZE'(gi))),
            .nonzero (credit_nz[gi])
         );
      end
   endgenerate

   assign tr_op      = op;
   assign busy       = (state_reg != IDLE);
   assign sent_flits = sent_flits_reg;

endmodule

// File: tb/tb_traffic_ctrl.sv
// Scoreboard bench for traffic_ctrl: stimulus queues expected commands, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_traffic_ctrl;
   import traffic_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [10:0] num_pkts = '0;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [31:0] cfg_data = '0;
   logic [2:0]  tr_op;
   logic [31:0] tr_data;
   logic [39:0] tr_buffer = '0;
   logic [3:0]  credit_ret = '0;
   logic        flit_valid, busy, finished;
   logic [19:0] sent_flits;
`ifdef TRAFFIC_CTRL_RATE_EN
   logic [7:0]  rate_gap = '0;
`endif

   traffic_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .num_pkts   (num_pkts),
`ifdef TRAFFIC_CTRL_RATE_EN
      .rate_gap   (rate_gap),
`endif
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_data   (cfg_data),
      .tr_op      (tr_op),
      .tr_data    (tr_data),
      .tr_buffer  (tr_buffer),
      .credit_ret (credit_ret),
      .flit_valid (flit_valid),
      .busy       (busy),
      .finished   (finished),
      .sent_flits (sent_flits)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] data;
      int          gap;   // >0 exact cycles since previous event, <0 minimum of -gap
      int          sent;  // expected sent_flits during the event, -1 = don't care
      logic        fin;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          tests = 0;
   int          fails = 0;
   longint      cyc = 0;
   longint      last_cyc = 0;
   logic [31:0] desc_mem[8];

   task automatic chk_ok(input string name, input bit ok, input longint act, input longint req);
      tests++;
      if (!ok) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic chk(input string name, input longint act, input longint req);
      chk_ok(name, act == req, act, req);
   endtask

   // Monitor: every command, flit or completion the DUT presents consumes one expected entry.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && (tr_op != 3'(OP_NOP) || finished || flit_valid)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event_op", longint'(tr_op), longint'(OP_NOP));
         end else begin
            mon_e = exp_q.pop_front();
            $display("[TB] event op=%0d data=%h fv=%0b fin=%0b sent=%0d gap=%0d",
                     tr_op, tr_data, flit_valid, finished, sent_flits, cyc - last_cyc);
            chk("op", longint'(tr_op), longint'(mon_e.op));
            chk("data", longint'(tr_data), longint'(mon_e.data));
            chk("flit_valid", longint'(flit_valid), longint'(mon_e.op == 3'(OP_DEQUEUE)));
            chk("finished", longint'(finished), longint'(mon_e.fin));
            if (mon_e.gap > 0) chk("gap", cyc - last_cyc, longint'(mon_e.gap));
            else chk_ok("gap_min", (cyc - last_cyc) >= longint'(-mon_e.gap), cyc - last_cyc, longint'(-mon_e.gap));
            if (mon_e.sent >= 0) chk("sent_flits", longint'(sent_flits), longint'(mon_e.sent));
         end
         last_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] op, input logic [31:0] data, input int gap, input int sent, input logic fin);
      exp_t e;
      e.op = op; e.data = data; e.gap = gap; e.sent = sent; e.fin = fin;
      exp_q.push_back(e);
   endtask

   task automatic expect_setup(input int n, input int ndesc, input int cfg_gap);
      push(3'(OP_INIT), 32'((n - 1) & 32'h7FF), -1, -1, 1'b0);
      for (int i = 0; i < ndesc; i++) push(3'(OP_FILL), desc_mem[i], (i == 0) ? 1 : cfg_gap + 1, -1, 1'b0);
      if (ndesc > 0) push(3'(OP_PREDEQUE), 32'h0, 1, -1, 1'b0);
   endtask

   task automatic expect_deqs(input int first, input int count, input int gap_first, input int gap_rest, input bit fin_last);
      for (int i = 0; i < count; i++)
         push(3'(OP_DEQUEUE), 32'h0, (i == 0) ? gap_first : gap_rest, first + i, fin_last && (i == count - 1));
   endtask

   task automatic set_vc(input int vc);
      tr_buffer = {4'h0, 1'b1, 1'b1, 2'(vc), 32'hA5A5_0000 | 32'(vc)};
   endtask

   // Pulse start with the first descriptor already offered, then hand over each descriptor.
   task automatic run_start(input int n, input int ndesc, input int cfg_gap);
      num_pkts = 11'(n);
      start    = 1'b1;
      if (ndesc > 0) begin
         cfg_valid = 1'b1;
         cfg_data  = desc_mem[0];
      end
      tick();
      start = 1'b0;
      for (int i = 0; i < ndesc; i++) begin
         int   b;
         logic hs;
         b = 0; hs = 1'b0;
         cfg_valid = 1'b1;
         cfg_data  = desc_mem[i];
         while (!hs && b < 50) begin
            @(negedge clk);
            hs = cfg_ready;
            tick();
            b++;
         end
         chk("cfg_handshake", longint'(hs), 1);
         if (i < ndesc - 1) begin
            cfg_valid = 1'b0;
            repeat (cfg_gap) tick();
         end
      end
      cfg_valid = 1'b0;
   endtask

   task automatic wait_flits(input int k);
      int seen, b;
      seen = 0; b = 0;
      while (seen < k && b < 200) begin
         @(negedge clk);
         if (flit_valid) seen++;
         b++;
      end
      chk("wait_flits", seen, k);
      tick();
   endtask

   task automatic wait_idle();
      int b;
      b = 0;
      do begin
         @(negedge clk);
         b++;
      end while (busy && b < 300);
      chk("idle_reached_busy", longint'(busy), 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      #2;
      chk("rst_tr_op", longint'(tr_op), longint'(OP_NOP));
      chk("rst_tr_data", longint'(tr_data), 0);
      chk("rst_cfg_ready", longint'(cfg_ready), 0);
      chk("rst_flit_valid", longint'(flit_valid), 0);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_finished", longint'(finished), 0);
      chk("rst_sent_flits", longint'(sent_flits), 0);
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();

      // 1 packet, 1 flit on VC0 with full credits
      set_vc(0);
      desc_mem[0] = build_desc(5, 0, 1);
      expect_setup(1, 1, 0);
      expect_deqs(0, 1, 2, 1, 1'b1);
      run_start(1, 1, 0);
      wait_idle();
      chk("single_sent_flits", longint'(sent_flits), 1);
      tick();

      // Zero-length descriptor counts as one flit; VC0 returns held throughout
      credit_ret = 4'b0001;
      desc_mem[0] = build_desc(1, 0, 0);
      desc_mem[1] = build_desc(2, 0, 2);
      expect_setup(2, 2, 0);
      expect_deqs(0, 3, 2, 1, 1'b1);
      run_start(2, 2, 0);
      wait_idle();
      chk("zero_len_sent_flits", longint'(sent_flits), 3);
      repeat (3) tick();
      credit_ret = 4'b0000;

      // 3 x 4 flits on VC1: stall after 4, ignored starts, then one return per cycle
      set_vc(1);
      for (int i = 0; i < 3; i++) desc_mem[i] = build_desc(7, 1, 4);
      expect_setup(3, 3, 2);
      expect_deqs(0, 4, 2, 1, 1'b0);
      expect_deqs(4, 8, -3, 1, 1'b1);
      run_start(3, 3, 2);
      wait_flits(4);
      tick();
      start = 1'b1; tick(); start = 1'b0; tick();
      start = 1'b1; tick(); start = 1'b0;
      credit_ret = 4'b0010;
      wait_idle();
      chk("burst_sent_flits", longint'(sent_flits), 12);
      repeat (6) tick();
      credit_ret = 4'b0000;

      // Returns while full are dropped: a 5-flit packet must still stall after 4
      credit_ret = 4'b1111;
      repeat (4) tick();
      credit_ret = 4'b0000;
      desc_mem[0] = build_desc(3, 1, 5);
      expect_setup(1, 1, 0);
      expect_deqs(0, 4, 2, 1, 1'b0);
      expect_deqs(4, 1, -3, 1, 1'b1);
      run_start(1, 1, 0);
      wait_flits(4);
      repeat (3) tick();
      credit_ret = 4'b0010; tick();
      credit_ret = 4'b0000;
      wait_idle();
      credit_ret = 4'b0010;
      repeat (5) tick();
      credit_ret = 4'b0000;

      // num_pkts = 0: Init then completion with no Fill/PreDeque
      expect_setup(0, 0, 0);
      push(3'(OP_NOP), 32'h0, 1, 0, 1'b1);
      run_start(0, 0, 0);
      wait_idle();
      chk("empty_sent_flits", longint'(sent_flits), 0);

      // Asynchronous reset while stalled in RUN
      set_vc(2);
      desc_mem[0] = build_desc(6, 2, 8);
      expect_setup(1, 1, 0);
      expect_deqs(0, 4, 2, 1, 1'b0);
      run_start(1, 1, 0);
      wait_flits(4);
      repeat (2) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_tr_op", longint'(tr_op), longint'(OP_NOP));
      chk("arst_tr_data", longint'(tr_data), 0);
      chk("arst_busy", longint'(busy), 0);
      chk("arst_flit_valid", longint'(flit_valid), 0);
      chk("arst_finished", longint'(finished), 0);
      chk("arst_sent_flits", longint'(sent_flits), 0);
      chk("arst_pending_expect", exp_q.size(), 0);
      tick();
      rst_n = 1'b1;
      tick();

      // Clean run after reset
      desc_mem[0] = build_desc(9, 2, 2);
      expect_setup(1, 1, 0);
      expect_deqs(0, 2, 2, 1, 1'b1);
      run_start(1, 1, 0);
      wait_idle();
      chk("post_reset_sent_flits", longint'(sent_flits), 2);

`ifdef TRAFFIC_CTRL_RATE_EN
      // rate_gap = 2: Dequeues three cycles apart
      set_vc(3);
      rate_gap   = 8'd2;
      credit_ret = 4'b1000;
      desc_mem[0] = build_desc(4, 3, 5);
      expect_setup(1, 1, 0);
      expect_deqs(0, 5, 2, 3, 1'b1);
      run_start(1, 1, 0);
      wait_idle();
      credit_ret = 4'b0000;
      rate_gap   = 8'd0;
      chk("rate_sent_flits", longint'(sent_flits), 5);
`endif

      repeat (3) tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
